// File: rtl/iob_csr_rsp.sv
// iob_csr_rsp: IOb-native subordinate serving a bank of software-visible
// control/status registers. Registers can be marked read-only or
// clear-on-read. A hardware-side port lets the owning peripheral load
// status values.
//
// Handshake: a request is taken when iob_valid_i && iob_ready_o on a rising
// edge of clk_i. A nonzero iob_wstrb_i marks a write, which is acknowledged
// by the accept itself and produces no rvalid. A zero strobe marks a read:
// iob_rvalid_o is high for exactly one cycle, one cycle after the accept.
// iob_rdata_o keeps its last value while iob_rvalid_o is low.
module iob_csr_rsp #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] RST_VAL = '0,
  parameter logic [(2**(ADDR_W-2))-1:0] RO_MASK  = '0,
  parameter logic [(2**(ADDR_W-2))-1:0] COR_MASK = '0
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   iob_valid_i,
  input  logic [ADDR_W-1:0]                      iob_addr_i,
  input  logic [DATA_W-1:0]                      iob_wdata_i,
  input  logic [DATA_W/8-1:0]                    iob_wstrb_i,
  output logic                                   iob_ready_o,
  output logic                                   iob_rvalid_o,
  output logic [DATA_W-1:0]                      iob_rdata_o,
  input  logic                                   hw_wen_i,
  input  logic [ADDR_W-3:0]                      hw_waddr_i,
  input  logic [DATA_W-1:0]                      hw_wdata_i,
  output logic [(2**(ADDR_W-2))*DATA_W-1:0]      regs_o
);

  localparam int NREGS  = 2**(ADDR_W-2);
  localparam int IDX_W  = ADDR_W-2;
  localparam int NBYTES = DATA_W/8;

  logic                ready_q;
  logic                rvalid_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [DATA_W-1:0]   regs_q [NREGS];
  logic [DATA_W-1:0]   regs_d [NREGS];

  logic                accept;
  logic                sw_wr;
  logic                sw_rd;
  logic [IDX_W-1:0]    sw_idx;

  // Decode the accepted request; the two low address bits are ignored.
  always_comb begin
    accept = iob_valid_i && ready_q;
    sw_wr  = accept && (iob_wstrb_i != '0);
    sw_rd  = accept && (iob_wstrb_i == '0);
    sw_idx = iob_addr_i[ADDR_W-1:2];
  end

  // Next register values. Priority from low to high: hold, clear-on-read,
  // hardware load, software strobed bytes. A read and a software write can
  // never target the same cycle, so clear-on-read only competes with the
  // hardware load, which wins so that status events are not lost.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (sw_rd && (sw_idx == IDX_W'(i)) && COR_MASK[i]) begin
        regs_d[i] = '0;
      end
      if (hw_wen_i && (hw_waddr_i == IDX_W'(i))) begin
        regs_d[i] = hw_wdata_i;
      end
      if (sw_wr && (sw_idx == IDX_W'(i)) && !RO_MASK[i]) begin
        for (int k = 0; k < NBYTES; k++) begin
          if (iob_wstrb_i[k]) begin
            regs_d[i][k*8 +: 8] = iob_wdata_i[k*8 +: 8];
          end
        end
      end
    end
  end

  // Register bank; reset takes priority so nothing commits during reset.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NREGS; i++) begin
      if (rst_i) begin
        regs_q[i] <= RST_VAL;
      end else begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Bus side: ready rises the cycle after reset releases; read data is the
  // register value from the accept cycle, before any same-cycle update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      ready_q  <= 1'b1;
      rvalid_q <= sw_rd;
      if (sw_rd) begin
        rdata_q <= regs_q[sw_idx];
      end
    end
  end

  // A read response still in flight when reset arrives is dropped at once.
  always_comb begin
    iob_ready_o  = ready_q;
    iob_rvalid_o = rvalid_q && !rst_i;
    iob_rdata_o  = rdata_q;
  end

  // Flattened register view straight from the flops.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_o[i*DATA_W +: DATA_W] = regs_q[i];
    end
  end

endmodule

// File: tb/tb_iob_csr_rsp.sv
// Directed bench for iob_csr_rsp. Instance 0 uses plain read/write
// registers; instance 1 has register 0 read-only and register 1
// clear-on-read.
module tb_iob_csr_rsp;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NREGS  = 8;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     valid  [2];
  logic [ADDR_W-1:0]        addr   [2];
  logic [DATA_W-1:0]        wdata  [2];
  logic [DATA_W/8-1:0]      wstrb  [2];
  logic                     ready  [2];
  logic                     rvalid [2];
  logic [DATA_W-1:0]        rdata  [2];
  logic                     hw_en  [2];
  logic [ADDR_W-3:0]        hw_idx [2];
  logic [DATA_W-1:0]        hw_dat [2];
  logic [NREGS*DATA_W-1:0]  regs   [2];

  int checks = 0;
  int errors = 0;

  // clock and reset
  always #5 clk = ~clk;

  iob_csr_rsp #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RST_VAL(32'h0),
    .RO_MASK(8'h00), .COR_MASK(8'h00)
  ) u_a (
    .clk_i(clk), .rst_i(rst),
    .iob_valid_i(valid[0]), .iob_addr_i(addr[0]), .iob_wdata_i(wdata[0]),
    .iob_wstrb_i(wstrb[0]), .iob_ready_o(ready[0]), .iob_rvalid_o(rvalid[0]),
    .iob_rdata_o(rdata[0]), .hw_wen_i(hw_en[0]), .hw_waddr_i(hw_idx[0]),
    .hw_wdata_i(hw_dat[0]), .regs_o(regs[0])
  );

  iob_csr_rsp #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RST_VAL(32'h0),
    .RO_MASK(8'h01), .COR_MASK(8'h02)
  ) u_b (
    .clk_i(clk), .rst_i(rst),
    .iob_valid_i(valid[1]), .iob_addr_i(addr[1]), .iob_wdata_i(wdata[1]),
    .iob_wstrb_i(wstrb[1]), .iob_ready_o(ready[1]), .iob_rvalid_o(rvalid[1]),
    .iob_rdata_o(rdata[1]), .hw_wen_i(hw_en[1]), .hw_waddr_i(hw_idx[1]),
    .hw_wdata_i(hw_dat[1]), .regs_o(regs[1])
  );

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int d, input logic [ADDR_W-1:0] a,
                     input logic [DATA_W-1:0] wd, input logic [3:0] ws);
    valid[d] = 1'b1;
    addr[d]  = a;
    wdata[d] = wd;
    wstrb[d] = ws;
  endtask

  task automatic idle(input int d);
    valid[d] = 1'b0;
    addr[d]  = '0;
    wdata[d] = '0;
    wstrb[d] = '0;
  endtask

  task automatic hw(input int d, input logic en, input logic [ADDR_W-3:0] i,
                    input logic [DATA_W-1:0] v);
    hw_en[d]  = en;
    hw_idx[d] = i;
    hw_dat[d] = v;
  endtask

  function automatic logic [DATA_W-1:0] word(input int d, input int i);
    return regs[d][i*DATA_W +: DATA_W];
  endfunction

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                     input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      idle(d);
      hw(d, 1'b0, '0, '0);
    end

    // reset and release
    step(); step(); step();
    chk("ready_a_in_reset", 32'(ready[0]), 32'h0);
    chk("ready_b_in_reset", 32'(ready[1]), 32'h0);
    chk("rvalid_a_in_reset", 32'(rvalid[0]), 32'h0);
    chk("rdata_a_in_reset", rdata[0], 32'h0);
    rst = 1'b0;
    step();
    chk("ready_a_after_reset", 32'(ready[0]), 32'h1);
    chk("ready_b_after_reset", 32'(ready[1]), 32'h1);
    chk("rvalid_a_after_reset", 32'(rvalid[0]), 32'h0);
    for (int i = 0; i < NREGS; i++) chk($sformatf("rst_word_a%0d", i), word(0, i), 32'h0);
    for (int i = 0; i < NREGS; i++) chk($sformatf("rst_word_b%0d", i), word(1, i), 32'h0);

    // full write, read back, partial write
    req(0, 5'h04, 32'hDEADBEEF, 4'hF);
    step(); idle(0);
    chk("write_no_rvalid", 32'(rvalid[0]), 32'h0);
    chk("write_full_word1", word(0, 1), 32'hDEADBEEF);
    req(0, 5'h04, 32'h0, 4'h0);
    step(); idle(0);
    chk("read_rvalid", 32'(rvalid[0]), 32'h1);
    chk("read_rdata", rdata[0], 32'hDEADBEEF);
    step();
    chk("rvalid_one_cycle", 32'(rvalid[0]), 32'h0);
    chk("rdata_holds", rdata[0], 32'hDEADBEEF);
    req(0, 5'h04, 32'h0000AA00, 4'h2);
    step(); idle(0);
    chk("write_byte1", word(0, 1), 32'hDEADAAEF);
    req(0, 5'h07, 32'hFFFFFFFF, 4'h0);
    step(); idle(0);
    chk("read_unaligned_rvalid", 32'(rvalid[0]), 32'h1);
    chk("read_unaligned_rdata", rdata[0], 32'hDEADAAEF);

    // read-only register
    req(1, 5'h00, 32'h12345678, 4'hF);
    step(); idle(1);
    chk("ro_write_dropped", word(1, 0), 32'h0);
    chk("ro_write_ready", 32'(ready[1]), 32'h1);
    hw(1, 1'b1, 3'd0, 32'h55);
    step(); hw(1, 1'b0, '0, '0);
    chk("ro_hw_write", word(1, 0), 32'h55);
    req(1, 5'h00, 32'hAAAAAAAA, 4'hF);
    hw(1, 1'b1, 3'd0, 32'h11);
    step(); idle(1); hw(1, 1'b0, '0, '0);
    chk("ro_hw_vs_sw", word(1, 0), 32'h11);

    // clear-on-read
    hw(1, 1'b1, 3'd1, 32'h9);
    step(); hw(1, 1'b0, '0, '0);
    chk("cor_hw_load", word(1, 1), 32'h9);
    req(1, 5'h04, 32'h0, 4'h0);
    step(); idle(1);
    chk("cor_read1_rvalid", 32'(rvalid[1]), 32'h1);
    chk("cor_read1_rdata", rdata[1], 32'h9);
    chk("cor_cleared", word(1, 1), 32'h0);
    req(1, 5'h04, 32'h0, 4'h0);
    step(); idle(1);
    chk("cor_read2_rvalid", 32'(rvalid[1]), 32'h1);
    chk("cor_read2_rdata", rdata[1], 32'h0);
    hw(1, 1'b1, 3'd1, 32'h7);
    step(); hw(1, 1'b0, '0, '0);
    req(1, 5'h04, 32'h0, 4'h0);
    hw(1, 1'b1, 3'd1, 32'h3);
    step(); idle(1); hw(1, 1'b0, '0, '0);
    chk("cor_hw_race_rdata", rdata[1], 32'h7);
    chk("cor_hw_race_reg", word(1, 1), 32'h3);

    // same-cycle software and hardware write
    req(0, 5'h08, 32'h0000BBBB, 4'h3);
    hw(0, 1'b1, 3'd2, 32'hCCCCCCCC);
    step(); idle(0); hw(0, 1'b0, '0, '0);
    chk("sw_hw_merge", word(0, 2), 32'hCCCCBBBB);

    // back-to-back reads with reset after the last accept
    req(0, 5'h00, 32'h01020304, 4'hF);
    step();
    req(0, 5'h00, 32'h0, 4'h0);
    step();
    chk("b2b_rvalid0", 32'(rvalid[0]), 32'h1);
    chk("b2b_rdata0", rdata[0], 32'h01020304);
    req(0, 5'h04, 32'h0, 4'h0);
    step();
    chk("b2b_rvalid1", 32'(rvalid[0]), 32'h1);
    chk("b2b_rdata1", rdata[0], 32'hDEADAAEF);
    req(0, 5'h08, 32'h0, 4'h0);
    step(); idle(0);
    rst = 1'b1;
    #1;
    chk("b2b_third_suppressed", 32'(rvalid[0]), 32'h0);
    step();
    chk("rst_mid_rvalid", 32'(rvalid[0]), 32'h0);
    chk("rst_mid_ready", 32'(ready[0]), 32'h0);
    rst = 1'b0;
    step();
    chk("post_rst_ready", 32'(ready[0]), 32'h1);
    chk("post_rst_rvalid", 32'(rvalid[0]), 32'h0);
    chk("post_rst_rdata", rdata[0], 32'h0);
    chk("post_rst_word0", word(0, 0), 32'h0);
    chk("post_rst_word2", word(0, 2), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
